// File: rtl/dmem_if.sv
// Request/response bus between a CPU load/store unit and a data-memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte/half/word loads and stores with
// configurable wait states, alignment/range checking and a held response.
module dmem_responder #(
  parameter int ENTRY_COUNT = 32,
  parameter int WAIT_STATES = 1
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem_q [ENTRY_COUNT];

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  logic            req_ready_c;
  logic            accept_c;
  logic            access_c;
  logic            use_live_c;
  logic            f_wr, f_uns;
  logic [1:0]      f_size;
  logic [31:0]     f_addr, f_wdata;
  logic [IDX_W-1:0] idx_c;
  logic            rsp_err_d;
  logic [31:0]     rsp_rdata_d;
  logic [3:0]      be_c;
  logic [31:0]     wlanes_c;

  assign req_ready_c = (state_q == IDLE) && !rst;
  assign accept_c    = bus.req_valid && req_ready_c;

  // With zero wait states the access happens on the accept edge itself, so the
  // live bus fields are used; otherwise the captured copy is used.
  assign use_live_c = (state_q == IDLE);
  assign f_wr    = use_live_c ? bus.req_wr       : wr_q;
  assign f_uns   = use_live_c ? bus.req_unsigned : uns_q;
  assign f_size  = use_live_c ? bus.req_size     : size_q;
  assign f_addr  = use_live_c ? bus.req_addr     : addr_q;
  assign f_wdata = use_live_c ? bus.req_wdata    : wdata_q;

  assign access_c = !rst && (((state_q == IDLE) && accept_c && (WAIT_STATES == 0)) ||
                             ((state_q == WAIT) && (cnt_q <= 4'd1)));

  assign idx_c     = f_addr[IDX_W+1:2];
  assign rsp_err_d = (f_size == 2'b11) ||
                     ((f_size == 2'b01) && f_addr[0]) ||
                     ((f_size == 2'b10) && (f_addr[1:0] != 2'b00)) ||
                     ({2'b00, f_addr[31:2]} >= 32'(ENTRY_COUNT));
  assign rsp_rdata_d = (f_wr || rsp_err_d) ? 32'h0
                                           : load_extract(mem_q[idx_c], f_addr[1:0], f_size, f_uns);
  assign be_c     = store_be(f_addr[1:0], f_size);
  assign wlanes_c = store_lanes(f_wdata, f_size);

  always_ff @(posedge clk) begin
    if (accept_c) begin
      wr_q    <= bus.req_wr;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (access_c && f_wr && !rsp_err_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wlanes_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            if (WAIT_STATES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= rsp_err_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q     <= RESP;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_STATES=1 and a WAIT_STATES=0 instance, checked
// against a byte-array memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          sel = 1'b0;
  logic        t_valid = 1'b0, t_wr = 1'b0, t_uns = 1'b0, t_rsp_ready = 1'b0;
  logic [31:0] t_addr = 32'h0, t_wdata = 32'h0;
  logic [1:0]  t_size = 2'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [2][128];

  dmem_if bus_a ();
  dmem_if bus_b ();

  dmem_responder #(.ENTRY_COUNT(32), .WAIT_STATES(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  dmem_responder #(.ENTRY_COUNT(32), .WAIT_STATES(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  assign bus_a.req_valid    = t_valid && !sel;
  assign bus_b.req_valid    = t_valid && sel;
  assign bus_a.rsp_ready    = t_rsp_ready && !sel;
  assign bus_b.rsp_ready    = t_rsp_ready && sel;
  assign bus_a.req_wr       = t_wr;
  assign bus_b.req_wr       = t_wr;
  assign bus_a.req_addr     = t_addr;
  assign bus_b.req_addr     = t_addr;
  assign bus_a.req_size     = t_size;
  assign bus_b.req_size     = t_size;
  assign bus_a.req_unsigned = t_uns;
  assign bus_b.req_unsigned = t_uns;
  assign bus_a.req_wdata    = t_wdata;
  assign bus_b.req_wdata    = t_wdata;

  wire        o_req_ready = sel ? bus_b.req_ready : bus_a.req_ready;
  wire        o_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  wire [31:0] o_rsp_rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  wire        o_rsp_err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;

  always #5 clk = ~clk;

  // Reference: memory as little-endian bytes; size is 1<<size bytes, natural alignment.
  task automatic model_access(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                              input bit uns, input logic [31:0] wd,
                              output logic [31:0] rd, output bit er);
    int unsigned n;
    longint val;
    n  = 1 << size;
    er = (size == 2'b11) || ((addr % n) != 0) || ((addr / 4) >= 32);
    rd = 32'h0;
    if (er) return;
    if (wr) begin
      for (int i = 0; i < int'(n); i++) ref_mem[sel][int'(addr) + i] = wd[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < int'(n); i++) val += longint'(ref_mem[sel][int'(addr) + i]) << (8 * i);
      if (!uns && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
      rd = val[31:0];
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er, output int lat);
    int n;
    @(negedge clk);
    t_wr = wr; t_addr = addr; t_size = size; t_uns = uns; t_wdata = wd; t_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!o_req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready got %b expected 1", o_req_ready);
    end
    @(posedge clk); #1;
    t_valid = 1'b0;
    t_wr = 1'($urandom); t_addr = $urandom; t_size = 2'($urandom); t_uns = 1'($urandom); t_wdata = $urandom;
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (!o_rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid got %b expected 1", o_rsp_valid);
    end
    rd = o_rsp_rdata;
    er = o_rsp_err;
  endtask

  task automatic consume();
    t_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      checks++;
      if ({o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata} !== 35'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: ready/valid/err/rdata got %b/%b/%b/%h expected 0/0/0/0",
                 s, o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata);
      end
    end
    sel = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", o_req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ready %b valid %b expected 1 0", o_req_ready, o_rsp_valid);
    end
  endtask

  task automatic test_init();
    logic [31:0] rd, mrd, wd;
    bit er, mer;
    int lat;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int w = 0; w < 32; w++) begin
        wd = $urandom;
        issue(1'b1, 32'(w * 4), 2'b10, 1'b0, wd, rd, er, lat);
        consume();
        model_access(1'b1, 32'(w * 4), 2'b10, 1'b0, wd, mrd, mer);
        checks++;
        if (er !== mer || rd !== mrd) begin
          errors++;
          $display("FAIL init_store[%0d:%0d]: err/rdata got %b/%h expected %b/%h", s, w, er, rd, mer, mrd);
        end
      end
    end
    sel = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_er;
    bit          from_model;
  } vec_t;

  task automatic test_directed();
    vec_t v [10];
    logic [31:0] rd, mrd, exp;
    bit er, mer;
    int lat;
    v[0] = '{1'b1, 32'h8,  2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    v[1] = '{1'b0, 32'h8,  2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    v[2] = '{1'b1, 32'h9,  2'b00, 1'b0, 32'h00000080, 32'h0,        1'b0, 1'b0};
    v[3] = '{1'b0, 32'h9,  2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0};
    v[4] = '{1'b0, 32'h9,  2'b00, 1'b1, 32'h0,        32'h00000080, 1'b0, 1'b0};
    v[5] = '{1'b0, 32'h8,  2'b10, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0, 1'b0};
    v[6] = '{1'b0, 32'h3,  2'b01, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    v[7] = '{1'b1, 32'h80, 2'b10, 1'b0, 32'h1,        32'h0,        1'b1, 1'b0};
    v[8] = '{1'b0, 32'h0,  2'b10, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
    v[9] = '{1'b0, 32'h0,  2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      issue(v[i].wr, v[i].addr, v[i].size, v[i].uns, v[i].wd, rd, er, lat);
      consume();
      model_access(v[i].wr, v[i].addr, v[i].size, v[i].uns, v[i].wd, mrd, mer);
      exp = v[i].from_model ? mrd : v[i].exp_rd;
      checks++;
      if (rd !== exp || er !== v[i].exp_er) begin
        errors++;
        $display("FAIL directed[%0d]: rdata/err got %h/%b expected %h/%b", i, rd, er, exp, v[i].exp_er);
      end
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d expected 2", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, mrd;
    bit er, mer;
    int lat;
    sel = 1'b0;
    issue(1'b0, 32'hA, 2'b01, 1'b0, 32'h0, rd, er, lat);
    model_access(1'b0, 32'hA, 2'b01, 1'b0, 32'h0, mrd, mer);
    checks++;
    if (rd !== mrd || er !== mer) begin
      errors++;
      $display("FAIL bp_data: rdata/err got %h/%b expected %h/%b", rd, er, mrd, mer);
    end
    t_wr = 1'b1; t_addr = 32'h8; t_size = 2'b10; t_wdata = 32'h0BADF00D; t_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== rd || o_rsp_err !== er || o_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid/rdata/err/ready got %b/%h/%b/%b expected 1/%h/%b/0",
                 c, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready, rd, er);
      end
    end
    t_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t_rsp_ready = 1'b0; t_valid = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid/ready got %b/%b expected 0/1", o_rsp_valid, o_req_ready);
    end
    issue(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, rd, er, lat);
    consume();
    model_access(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, mrd, mer);
    checks++;
    if (rd !== mrd) begin
      errors++;
      $display("FAIL bp_ignored_store: LW 0x8 got %h expected %h", rd, mrd);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, mrd;
    bit er, mer;
    int lat, n;
    sel = 1'b0;
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hCAFEF00D, rd, er, lat);
    consume();
    model_access(1'b1, 32'h10, 2'b10, 1'b0, 32'hCAFEF00D, mrd, mer);
    @(negedge clk);
    t_wr = 1'b1; t_addr = 32'h10; t_size = 2'b10; t_uns = 1'b0; t_wdata = 32'h12345678; t_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    t_valid = 1'b0; rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin @(negedge clk); rst = 1'b0; end
      @(posedge clk); #1;
      checks++;
      if (o_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_abort_valid[%0d]: got %b expected 0", c, o_rsp_valid);
      end
    end
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
    consume();
    model_access(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, mrd, mer);
    checks++;
    if (rd !== 32'hCAFEF00D || rd !== mrd) begin
      errors++;
      $display("FAIL wait_abort_mem: LW 0x10 got %h expected %h", rd, mrd);
    end
    issue(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, rd, er, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL resp_drop: valid/rdata/err got %b/%h/%b expected 0/0/0", o_rsp_valid, o_rsp_rdata, o_rsp_err);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_drop_idle: valid/ready got %b/%b expected 0/1", o_rsp_valid, o_req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, addr, wd;
    logic [1:0] size;
    bit er, mer, wr, uns;
    int lat, exp_lat;
    for (int i = 0; i < 200; i++) begin
      sel  = 1'($urandom);
      wr   = 1'($urandom);
      uns  = 1'($urandom);
      size = 2'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 135));
      wd   = $urandom;
      issue(wr, addr, size, uns, wd, rd, er, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      consume();
      model_access(wr, addr, size, uns, wd, mrd, mer);
      exp_lat = sel ? 1 : 2;
      checks++;
      if (rd !== mrd || er !== mer || lat != exp_lat) begin
        errors++;
        $display("FAIL random[%0d] sel%0d wr%0d a=%h sz%0d u%0d: rdata/err/lat got %h/%b/%0d expected %h/%b/%0d",
                 i, sel, wr, addr, size, uns, rd, er, lat, mrd, mer, exp_lat);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] mrd;
    bit mer;
    sel = 1'b1;
    @(negedge clk);
    t_wr = 1'b1; t_addr = 32'h4; t_size = 2'b10; t_uns = 1'b0; t_wdata = 32'h0000A5A5;
    t_valid = 1'b1; t_rsp_ready = 1'b1;
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b expected 1", o_req_ready);
    end
    @(posedge clk); #1;
    model_access(1'b1, 32'h4, 2'b10, 1'b0, 32'h0000A5A5, mrd, mer);
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b0 || o_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_store_rsp: valid/err/rdata got %b/%b/%h expected 1/0/0", o_rsp_valid, o_rsp_err, o_rsp_rdata);
    end
    t_wr = 1'b0; t_wdata = $urandom;
    @(posedge clk); #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: valid/ready got %b/%b expected 0/1", o_rsp_valid, o_req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h0000A5A5 || o_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load_rsp: valid/rdata/err got %b/%h/%b expected 1/0000a5a5/0", o_rsp_valid, o_rsp_rdata, o_rsp_err);
    end
    t_valid = 1'b0;
    @(posedge clk); #1;
    t_rsp_ready = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: valid got %b expected 0", o_rsp_valid);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter ENTRY_COUNT, default 32, giving the number of 32-bit memory words.
REQ-002 The module SHALL have parameter WAIT_STATES, default 1, giving the number of extra access cycles, legal range 0-15.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset, as the following two ports.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  the CPU presents a request.
REQ-007 req_ready  output  1  the responder accepts a request this cycle.
REQ-008 req_wr  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 req_unsigned  input  1  zero-extend a load instead of sign-extending it.
REQ-012 req_wdata  input  32  store data, right-aligned.
REQ-013 rsp_valid  output  1  a response is available.
REQ-014 rsp_ready  input  1  the CPU consumes the response.
REQ-015 rsp_rdata  output  32  load result; 0 for stores and for errors.
REQ-016 rsp_err  output  1  the request was misaligned, reserved or out of range.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-018 Accept SHALL occur on a rising edge where req_valid and req_ready are both 1; the request fields SHALL be captured on that edge, and later changes to them SHALL be ignored.
REQ-019 On accept, the FSM SHALL go to WAIT and load the wait counter with WAIT_STATES; when WAIT_STATES is 0 it SHALL go directly to RESP.
REQ-020 In WAIT, the counter SHALL decrement each cycle; the edge on which it would reach 0 SHALL move the FSM to RESP. rsp_valid SHALL first be high exactly WAIT_STATES+1 cycles after the accept edge.
REQ-021 The memory access (store write, load data capture) SHALL occur on the edge entering RESP.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_valid and rsp_ready are both 1; the FSM SHALL then return to IDLE, with req_ready=1 in the next cycle.
REQ-023 There SHALL be no overlap: at most one request is outstanding, and req_valid outside IDLE SHALL be ignored.
REQ-024 The word index SHALL be req_addr[31:2], and the byte lane SHALL be req_addr[1:0].
REQ-025 Error conditions are:
- req_size=11;
- half access with addr[0]=1;
- word access with addr[1:0]!=0;
- word index >= ENTRY_COUNT.
REQ-026 On error, the responder SHALL produce rsp_err=1 and rsp_rdata=0 with the normal latency, and SHALL NOT write memory.
REQ-027 A byte store SHALL write req_wdata[7:0] into lane addr[1:0]; a half store SHALL write req_wdata[15:0] into lanes {addr[1],0} and {addr[1],1}; a word store SHALL write all lanes; untouched bytes SHALL keep their value.
REQ-028 A load SHALL extract the addressed byte or half, then sign-extend it to 32 bits unless req_unsigned=1, in which case it SHALL zero-extend; for word loads, req_unsigned SHALL be ignored.
REQ-029 A successful store SHALL respond with rsp_err=0 and rsp_rdata=0.
REQ-030 Memory is little-endian: lane 0 SHALL be bits [7:0].

Reset
REQ-031 While rst=1: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
REQ-032 In the first cycle after rst deasserts, req_ready SHALL be 1.
REQ-033 Reset asserted in WAIT SHALL abort the request: no memory write, and no response issued.
REQ-034 Reset asserted in RESP SHALL drop the pending response.
REQ-035 Memory array contents SHALL NOT be affected by reset.

Verification (ENTRY_COUNT=32, WAIT_STATES=1 unless stated)
REQ-036 SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid high 2 cycles after each accept edge.
REQ-037 SB addr 0x9 data 0x00000080, then:
- LB 0x9 -> 0xFFFFFF80;
- LBU 0x9 -> 0x00000080;
- LW 0x8 -> 0xDEAD80EF.
REQ-038 LH 0x3 -> rsp_err=1, rsp_rdata=0; SW 0x80 data 0x1 -> rsp_err=1; a following LW 0x0 is unchanged; req_size=11 -> rsp_err=1.
REQ-039 Load response with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err remain stable and req_ready stays 0; rsp_ready=1 -> rsp_valid=0 and req_ready=1 in the next cycle.
REQ-040 SW 0x10 data 0x12345678 with rst pulsed in WAIT -> no rsp_valid; after reset, LW 0x10 returns the prior content.
REQ-041 WAIT_STATES=0 build: accept edge followed by rsp_valid=1 in the very next cycle; back-to-back SW/LW 0x4 data 0x0000A5A5 -> 0x0000A5A5, one request per 2 cycles with rsp_ready held at 1.
